// File: rtl/memoria_dados_espera_if.sv
// Load/store bus between the memory stage and the wait-state data memory.
// Handshake: the requester holds LeMem/EscreveMem until the one-cycle Pronto pulse; Ocupado stalls the pipeline meanwhile.
interface memoria_dados_espera_if;
    logic        LeMem;
    logic        EscreveMem;
    logic [31:0] Endereco;
    logic [31:0] DadoEscrita;
    logic [31:0] DadoLeitura;
    logic        Pronto;
    logic        Ocupado;
    logic        ErroEnd;

    modport master (
        output LeMem, EscreveMem, Endereco, DadoEscrita,
        input  DadoLeitura, Pronto, Ocupado, ErroEnd
    );

    modport slave (
        input  LeMem, EscreveMem, Endereco, DadoEscrita,
        output DadoLeitura, Pronto, Ocupado, ErroEnd
    );
endinterface

// File: rtl/memoria_dados_espera.sv
// Word-organised data memory with LATENCIA wait states per valid access.
// Invalid requests (both strobes, misaligned, out of range) complete in one cycle with ErroEnd.
module memoria_dados_espera #(
    parameter int PROF     = 256,
    parameter int LATENCIA = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    memoria_dados_espera_if.slave   bus,
    output logic [1:0]              estadoDbg
);
    localparam int AW = (PROF > 1) ? $clog2(PROF) : 1;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESPERA  = 2'd1,
        CONCLUI = 2'd2
    } estado_t;

    estado_t estado, proxEstado;

    logic [3:0]    contador;
    logic [AW-1:0] indiceReg;
    logic [31:0]   dadoReg;
    logic          escritaReg;
    logic [31:0]   mem [PROF];

    logic          requisicao;
    logic          invalida;
    logic          aceita;
    logic          termina;
    logic          prontoReg;
    logic          erroReg;
    logic [31:0]   leituraReg;
    logic [31:0]   indiceCompleto;

    assign requisicao     = bus.LeMem | bus.EscreveMem;
    assign indiceCompleto = {2'b00, bus.Endereco[31:2]};
    assign invalida       = (bus.LeMem & bus.EscreveMem)
                          | (bus.Endereco[1:0] != 2'b00)
                          | (indiceCompleto >= 32'(PROF));

    always_comb begin
        proxEstado = estado;
        aceita     = 1'b0;
        termina    = 1'b0;
        case (estado)
            OCIOSO: begin
                if (requisicao) begin
                    aceita     = 1'b1;
                    proxEstado = invalida ? CONCLUI : ESPERA;
                end
            end
            ESPERA: begin
                if (contador == 4'd0) begin
                    termina    = 1'b1;
                    proxEstado = CONCLUI;
                end
            end
            CONCLUI: proxEstado = OCIOSO;
            default: proxEstado = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado     <= OCIOSO;
            contador   <= 4'd0;
            prontoReg  <= 1'b0;
            erroReg    <= 1'b0;
            leituraReg <= 32'h0;
        end else begin
            estado    <= proxEstado;
            prontoReg <= (proxEstado == CONCLUI);
            erroReg   <= aceita & invalida;
            if (aceita && !invalida)
                contador <= 4'(LATENCIA - 1);
            else if (estado == ESPERA && contador != 4'd0)
                contador <= contador - 4'd1;
            if (termina && !escritaReg)
                leituraReg <= mem[indiceReg];
        end
    end

    // Request fields are captured once; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (aceita) begin
            indiceReg  <= bus.Endereco[AW+1:2];
            dadoReg    <= bus.DadoEscrita;
            escritaReg <= bus.EscreveMem;
        end
    end

    // A reset arriving on the completing edge discards the pending write.
    always_ff @(posedge clk) begin
        if (!reset && termina && escritaReg)
            mem[indiceReg] <= dadoReg;
    end

    assign bus.Ocupado     = (estado == ESPERA) | ((estado == OCIOSO) & requisicao);
    assign bus.Pronto      = prontoReg;
    assign bus.ErroEnd     = erroReg;
    assign bus.DadoLeitura = leituraReg;
    assign estadoDbg       = estado;
endmodule

// File: tb/tb_memoria_dados_espera.sv
// Bench for memoria_dados_espera: directed table, corner sequences and random traffic vs. a reference model.
module tb_memoria_dados_espera;
    localparam int PROF = 256;
    localparam int LAT  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] estadoDbg;
    logic [1:0] estadoDbg1;

    memoria_dados_espera_if bus ();
    memoria_dados_espera_if bus1 ();

    memoria_dados_espera #(.PROF(PROF), .LATENCIA(LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus), .estadoDbg(estadoDbg)
    );

    memoria_dados_espera #(.PROF(16), .LATENCIA(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .estadoDbg(estadoDbg1)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        le;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        expErr;
        logic [31:0] expDado;
        int          expLat;
    } vetor_t;

    vetor_t tabela[10];

    // Reference model: word contents known to the bench and the expected read register.
    logic [31:0] refMem [int];
    logic [31:0] expDado;

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nome, act, exp);
        end
    endtask

    function automatic bit valida(input logic le, input logic we, input logic [31:0] addr);
        int unsigned palavra;
        palavra = addr / 4;
        return !(le && we) && (addr % 4 == 0) && (palavra < PROF);
    endfunction

    task automatic modelo(input logic le, input logic we, input logic [31:0] addr, input logic [31:0] data);
        if (valida(le, we, addr)) begin
            if (we) refMem[int'(addr / 4)] = data;
            else    expDado = refMem[int'(addr / 4)];
        end
    endtask

    // One full handshake: drive, wait for Pronto (bounded), then release on the completing edge.
    task automatic doAccess(input logic le, input logic we, input logic [31:0] addr,
                            input logic [31:0] data, output int lat, output int ocup,
                            output logic err, output logic [31:0] rd);
        lat  = -1;
        ocup = 0;
        err  = 1'bx;
        rd   = 32'hx;
        @(posedge clk); #1;
        bus.LeMem       = le;
        bus.EscreveMem  = we;
        bus.Endereco    = addr;
        bus.DadoEscrita = data;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.Ocupado) ocup++;
            if (bus.Pronto) begin
                lat = c;
                err = bus.ErroEnd;
                rd  = bus.DadoLeitura;
                break;
            end
        end
        @(posedge clk); #1;
        bus.LeMem      = 1'b0;
        bus.EscreveMem = 1'b0;
    endtask

    initial begin
        int          lat, ocup;
        logic        err;
        logic [31:0] rd;
        logic [5:0]  prontoV, ocupV, erroV;
        int          vistoPronto;

        tabela[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0000_0000, 3};
        tabela[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEADBEEF, 3};
        tabela[2] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'hDEADBEEF, 1};
        tabela[3] = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'hDEADBEEF, 3};
        tabela[4] = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_0001, 1'b1, 32'hDEADBEEF, 1};
        tabela[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1111_1111, 3};
        tabela[6] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_2222, 1'b1, 32'h1111_1111, 1};
        tabela[7] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1111_1111, 3};
        tabela[8] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_C0DE, 1'b0, 32'h1111_1111, 3};
        tabela[9] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h1111_1111, 1};

        // Clock/reset
        reset = 1'b1;
        bus.LeMem = 1'b0;  bus.EscreveMem = 1'b0;  bus.Endereco = 32'h0;  bus.DadoEscrita = 32'h0;
        bus1.LeMem = 1'b0; bus1.EscreveMem = 1'b0; bus1.Endereco = 32'h0; bus1.DadoEscrita = 32'h0;
        expDado = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pronto", {31'h0, bus.Pronto}, 32'h0);
        check("reset_erro", {31'h0, bus.ErroEnd}, 32'h0);
        check("reset_dado", bus.DadoLeitura, 32'h0);
        check("reset_estado", {30'h0, estadoDbg}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("idle_ocupado", {31'h0, bus.Ocupado}, 32'h0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            doAccess(tabela[i].le, tabela[i].we, tabela[i].addr, tabela[i].data, lat, ocup, err, rd);
            modelo(tabela[i].le, tabela[i].we, tabela[i].addr, tabela[i].data);
            check($sformatf("tab%0d_lat", i), 32'(lat), 32'(tabela[i].expLat));
            check($sformatf("tab%0d_ocupado", i), 32'(ocup), 32'(tabela[i].expLat));
            check($sformatf("tab%0d_erro", i), {31'h0, err}, {31'h0, tabela[i].expErr});
            check($sformatf("tab%0d_dado", i), rd, tabela[i].expDado);
        end

        // Reset during ESPERA discards the pending write
        @(posedge clk); #1;
        bus.EscreveMem  = 1'b1;
        bus.Endereco    = 32'h20;
        bus.DadoEscrita = 32'hCAFEF00D;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("rst_mid_estado", {30'h0, estadoDbg}, 32'd1);
        check("rst_mid_pronto", {31'h0, bus.Pronto}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.EscreveMem = 1'b0;
        @(negedge clk);
        check("rst_after_erro", {31'h0, bus.ErroEnd}, 32'h0);
        check("rst_after_dado", bus.DadoLeitura, 32'h0);
        check("rst_after_ocupado", {31'h0, bus.Ocupado}, 32'h0);
        vistoPronto = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.Pronto) vistoPronto++;
            @(negedge clk);
        end
        check("rst_no_pronto", 32'(vistoPronto), 32'h0);
        expDado = 32'h0;
        doAccess(1'b1, 1'b0, 32'h20, 32'h0, lat, ocup, err, rd);
        modelo(1'b1, 1'b0, 32'h20, 32'h0);
        check("rst_read_lat", 32'(lat), 32'(LAT + 1));
        check("rst_read_dado", rd, expDado);

        // Reset together with a request: the request is not accepted
        @(posedge clk); #1;
        reset = 1'b1;
        bus.LeMem = 1'b1;
        bus.Endereco = 32'h0;
        @(posedge clk); #1;
        bus.LeMem = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_estado", {30'h0, estadoDbg}, 32'h0);
        check("rst_req_dado", bus.DadoLeitura, 32'h0);
        expDado = 32'h0;

        // LATENCIA=1, request held across two back-to-back reads
        @(posedge clk); #1;
        bus1.LeMem = 1'b1;
        bus1.Endereco = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            prontoV[c] = bus1.Pronto;
            ocupV[c]   = bus1.Ocupado;
            erroV[c]   = bus1.ErroEnd;
            if (c == 2) begin
                @(posedge clk); #1 bus1.Endereco = 32'h4;
            end
        end
        @(posedge clk); #1 bus1.LeMem = 1'b0;
        check("b2b_pronto", {26'h0, prontoV}, 32'b100100);
        check("b2b_ocupado", {26'h0, ocupV}, 32'b011011);
        check("b2b_erro", {26'h0, erroV}, 32'h0);

        // Random traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            int unsigned r, idx;
            logic        le, we, ok;
            logic [31:0] addr, data;
            r    = $urandom_range(0, 9);
            idx  = $urandom_range(0, PROF + 7);
            addr = idx * 4;
            data = $urandom;
            le   = (r < 4) || (r >= 8);
            we   = (r >= 4) && (r <= 8);
            if (r == 9) addr = addr + 32'($urandom_range(1, 3));
            if (le && !we && valida(le, we, addr) && !refMem.exists(int'(idx))) begin
                le = 1'b0;
                we = 1'b1;
            end
            ok = valida(le, we, addr);
            doAccess(le, we, addr, data, lat, ocup, err, rd);
            modelo(le, we, addr, data);
            check($sformatf("rnd%0d_lat", n), 32'(lat), ok ? 32'(LAT + 1) : 32'd1);
            check($sformatf("rnd%0d_ocupado", n), 32'(ocup), ok ? 32'(LAT + 1) : 32'd1);
            check($sformatf("rnd%0d_erro", n), {31'h0, err}, {31'h0, !ok});
            check($sformatf("rnd%0d_dado", n), rd, expDado);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memoria_dados_espera.md
# memoria_dados_espera

Word-organised data memory that serves the datapath's load/store requests with a configurable number of wait states. It sits on the memory stage: the main control's LeMem/EscreveMem strobes and the ALU-computed address drive it. It raises a stall (Ocupado) while an access is pending, and pulses Pronto when the access completes.

## Interface
- PROF, 256 — depth in 32-bit words; power of two, 2..65536.
- LATENCIA, 2 — wait-state cycles per valid access; 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- LeMem  in  1  read request; held by the requester until Pronto.
- EscreveMem  in  1  write request; held by the requester until Pronto.
- Endereco  in  32  byte address; bits [1:0] must be 00.
- DadoEscrita  in  32  write data.
- DadoLeitura  out  32  read data; valid while Pronto=1 after a read, then held.
- Pronto  out  1  one-cycle completion pulse, registered.
- Ocupado  out  1  stall to the PC/pipeline registers, combinational.
- ErroEnd  out  1  one-cycle error flag, coincident with Pronto.

## Operation
- States: OCIOSO, ESPERA, CONCLUI. Request = LeMem | EscreveMem.
- OCIOSO with no request: nothing happens and Ocupado=0.
- OCIOSO with a request: the request is accepted on that edge.
  - Latch address, data and type (read/write).
  - Ocupado=1 combinationally in this cycle.
- A request is invalid if any of the following holds:
  - LeMem and EscreveMem are both 1;
  - Endereco[1:0] != 0;
  - the word index Endereco[31:2] >= PROF.
- Invalid request: go OCIOSO -> CONCLUI directly.
  - ErroEnd=1 and Pronto=1 in CONCLUI.
  - No array access; DadoLeitura is unchanged.
- Valid request: go OCIOSO -> ESPERA and load the counter with LATENCIA-1.
- ESPERA: the counter decrements each cycle and Ocupado=1. At count 0 the block moves to CONCLUI.
  - Read: on the ESPERA -> CONCLUI edge, DadoLeitura <= mem[index].
  - Write: on the same edge, mem[index] <= the latched DadoEscrita.
  - Input changes during ESPERA are ignored; only the latched values are used.
- CONCLUI: Pronto=1, Ocupado=0 and the input request is ignored. The next state is always OCIOSO.
  - The requester advances on this edge, so a request still present in the next OCIOSO cycle is treated as a new access.
- Only the word index Endereco[log2(PROF)+1:2] addresses the array. Upper bits are used only for the range check.
- Array contents are not initialised or cleared by reset.

## Timing
- Reset values:
  - state = OCIOSO, counter = 0;
  - Pronto = 0, ErroEnd = 0, DadoLeitura = 32'h0;
  - Ocupado = 0 once reset deasserts with no request.
- Valid access, request first visible in cycle 0:
  - Ocupado=1 in cycles 0..LATENCIA;
  - Pronto=1 in cycle LATENCIA+1;
  - total latency is LATENCIA+1 cycles.
- Invalid access: Ocupado=1 in cycle 0; Pronto=ErroEnd=1 in cycle 1.
- Back-to-back requests: each one costs LATENCIA+2 cycles, counting the single OCIOSO cycle between them.
- Read-after-write to the same address returns the new data, because the write commits before the next acceptance.
- Reset asserted in any state:
  - the block returns to OCIOSO on that edge;
  - a pending write is discarded and the array is untouched;
  - no Pronto is issued.
- Reset and request in the same cycle: reset wins and the request is not accepted.
- Request dropped during ESPERA: the access still completes and Pronto still pulses.

## Test plan
- Write then read: LATENCIA=2.
  - EscreveMem, Endereco=0x10, DadoEscrita=0xDEADBEEF -> Ocupado=1 for 3 cycles, Pronto on the 4th cycle.
  - LeMem at 0x10 -> Pronto with DadoLeitura=0xDEADBEEF and ErroEnd=0.
- Misaligned address: LeMem with Endereco=0x13 -> Pronto=ErroEnd=1 one cycle after the request; DadoLeitura keeps its prior value.
- Out of range: PROF=256, EscreveMem at 0x400 with data 0x1 -> ErroEnd=1. A subsequent read of 0x000 returns the pre-existing value, showing there was no aliasing write.
- Both strobes: LeMem=EscreveMem=1 -> ErroEnd=1 and no array change.
- Reset mid-ESPERA: a write of 0xCAFEF00D to 0x20 is interrupted by reset in cycle 1 -> no Pronto, and all outputs return to 0. A read of 0x20 afterwards returns the old contents.
- LATENCIA=1, back-to-back reads at 0x0 then 0x4 with the request held continuously -> Pronto in cycles 2 and 5, and Ocupado=0 in cycles 2 and 5.
